// File: rtl/l0_seq.sv
`default_nettype none
// ============================================================================
//  Module   : l0_seq
//  Purpose  : Sequencer for the L0 row-staggered input buffer. Streams a
//             block of activation vectors from SRAM into L0, drains them into
//             the systolic array, waits out the per-row read skew, then
//             pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module l0_seq #(
  parameter int row    = 8,    // L0 rows; sets the flush length
  parameter int bw     = 4,    // activation width, sanity-checked only
  parameter int depth  = 64,   // L0 FIFO depth; largest legal num_vec
  parameter int addr_w = 11    // activation SRAM address width
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [6:0]        num_vec,
  input  logic              array_ready,
  input  logic              l0_full,
  input  logic              l0_ready,
  output logic              sram_cen,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                 flush_w    = $clog2(row + 1);
  localparam logic [6:0]         depth_v    = 7'(depth);
  localparam logic [flush_w-1:0] flush_last = flush_w'(row - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (bw < 1 || row < 1 || depth < 1 || depth > 127 || addr_w < 7) begin : g_param_check
    $error("l0_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic [addr_w-1:0]   base_q;
  logic [6:0]          num_q;
  logic [6:0]          issued;
  logic [6:0]          drained;
  logic [flush_w-1:0]  flush_cnt;

  logic                accept;
  logic                issue;
  logic                drain;
  logic [6:0]          num_clamped;
  logic [addr_w-1:0]   issue_addr;

  // Oversized requests are clamped to what L0 can physically hold.
  assign num_clamped = (num_vec > depth_v) ? depth_v : num_vec;

  // On the accepting edge the captured registers are not loaded yet, so the
  // first address comes straight from the port; afterwards from the capture.
  assign issue_addr = accept ? base_addr : (base_q + addr_w'(issued));

  assign busy = (state != S_IDLE);

  // Next-state decode plus the per-cycle issue/drain decisions. Because the
  // strobes are registered, the ready flags seen on an edge decide the
  // strobes driven during the following cycle.
  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    issue     = 1'b0;
    drain     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_clamped == 7'd0) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_LOAD;
            issue     = l0_ready;
          end
        end
      end
      S_LOAD: begin
        if (issued == num_q) begin
          nxt_state = S_WAIT;
        end else begin
          issue = l0_ready;
        end
      end
      S_WAIT: begin
        // Final write lands this cycle; at least one vector is pending.
        nxt_state = S_DRAIN;
        drain     = array_ready;
      end
      S_DRAIN: begin
        if (drained == num_q) begin
          nxt_state = S_FLUSH;
        end else begin
          drain = array_ready;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == flush_last) begin
          nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State register, captured command and the progress counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      drained   <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        base_q  <= base_addr;
        num_q   <= num_clamped;
        issued  <= {6'd0, issue};
        drained <= '0;
      end else begin
        if (issue) begin
          issued <= issued + 7'd1;
        end
        if (drain) begin
          drained <= drained + 7'd1;
        end
      end
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + flush_w'(1) : '0;
    end
  end

  // Registered outputs: SRAM port, L0 strobes, done pulse and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_cen  <= 1'b1;
      sram_addr <= '0;
      l0_wr     <= 1'b0;
      l0_rd     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sram_cen <= ~issue;
      if (issue) begin
        sram_addr <= issue_addr;
      end
      // One-cycle SRAM latency: write follows its read by exactly one cycle.
      l0_wr <= ~sram_cen;
      l0_rd <= drain;
      done  <= (nxt_state == S_DONE);
      if (accept) begin
        err <= 1'b0;
      end else if (l0_wr && l0_full) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l0_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l0_seq
//  Purpose  : Self-checking bench for l0_seq. Each operation's expected
//             waveform is derived from a schedule built out of the ready
//             traces, then compared cycle by cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l0_seq;

  localparam int rows  = 8;
  localparam int max_c = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [6:0]  num_vec;
  logic        array_ready;
  logic        l0_full;
  logic        l0_ready;
  logic        sram_cen;
  logic [10:0] sram_addr;
  logic        l0_wr;
  logic        l0_rd;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Per-cycle input traces for one operation (index = cycle since start).
  bit lr_tr[max_c];
  bit ar_tr[max_c];
  bit full_tr[max_c];
  bit st_tr[max_c];

  // Expected per-cycle outputs.
  logic        exp_cen[max_c];
  logic [10:0] exp_addr[max_c];
  logic        exp_wr[max_c];
  logic        exp_rd[max_c];
  logic        exp_busy[max_c];
  logic        exp_done[max_c];
  logic        exp_err[max_c];

  logic [10:0] prev_addr = 11'd0;
  logic        prev_err  = 1'b0;

  l0_seq #(.row(rows), .bw(4), .depth(64), .addr_w(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_vec     (num_vec),
    .array_ready (array_ready),
    .l0_full     (l0_full),
    .l0_ready    (l0_ready),
    .sram_cen    (sram_cen),
    .sram_addr   (sram_addr),
    .l0_wr       (l0_wr),
    .l0_rd       (l0_rd),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_traces(input bit rnd);
    for (int i = 0; i < max_c; i++) begin
      lr_tr[i]   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ar_tr[i]   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      full_tr[i] = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      st_tr[i]   = 1'b0;
    end
  endtask

  // Build the expected schedule, then drive the operation and compare.
  // A read is issued in cycle t when L0 was ready in cycle t-1 and reads
  // remain; likewise for drains against array_ready.
  task automatic run_op(input logic [10:0] base, input logic [6:0] nv, input bit mid_start,
                        input int reset_at, output int obs_done, output int n_wr,
                        output int n_rd, output int n_cen);
    int          n;
    int          cnt;
    int          t;
    int          last_issue;
    int          last_rd;
    int          done_c;
    int          last;
    logic [10:0] a;
    logic        e;
    bit          iss[max_c];
    logic [10:0] iaddr[max_c];

    for (int i = 0; i < max_c; i++) begin
      exp_cen[i]  = 1'b1;
      exp_wr[i]   = 1'b0;
      exp_rd[i]   = 1'b0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
      iss[i]      = 1'b0;
      iaddr[i]    = 11'd0;
    end
    n          = (nv > 7'd64) ? 64 : int'(nv);
    last_issue = 1;
    if (n == 0) begin
      done_c = 1;
    end else begin
      cnt = 0;
      t   = 1;
      while (cnt < n && t < max_c - 400) begin
        if (lr_tr[t-1]) begin
          iss[t]       = 1'b1;
          iaddr[t]     = base + 11'(cnt);
          exp_cen[t]   = 1'b0;
          exp_wr[t+1]  = 1'b1;
          cnt++;
          last_issue   = t;
        end
        t++;
      end
      cnt     = 0;
      t       = last_issue + 2;
      last_rd = t;
      while (cnt < n && t < max_c - 40) begin
        if (ar_tr[t-1]) begin
          exp_rd[t] = 1'b1;
          cnt++;
          last_rd   = t;
        end
        t++;
      end
      done_c = last_rd + rows + 1;
    end
    for (int i = 1; i <= done_c; i++) exp_busy[i] = 1'b1;
    exp_done[done_c] = 1'b1;
    last = done_c + 2;

    a = prev_addr;
    e = prev_err;
    for (int i = 0; i <= last; i++) begin
      if (iss[i]) a = iaddr[i];
      exp_addr[i] = a;
      if (i == 1) e = 1'b0;
      if (i >= 1 && exp_wr[i-1] && full_tr[i-1]) e = 1'b1;
      exp_err[i] = e;
    end

    if (mid_start && n > 0) begin
      st_tr[last_issue + 3] = 1'b1;
      st_tr[done_c]         = 1'b1;
    end

    if (reset_at >= 0) begin
      for (int i = reset_at; i < max_c; i++) begin
        exp_cen[i]  = 1'b1;
        exp_addr[i] = 11'd0;
        exp_wr[i]   = 1'b0;
        exp_rd[i]   = 1'b0;
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0;
        exp_err[i]  = 1'b0;
      end
      last = reset_at + 2;
    end

    obs_done = -1;
    n_wr     = 0;
    n_rd     = 0;
    n_cen    = 0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      start       = (c == 0) | st_tr[c];
      base_addr   = (c == 0) ? base : 11'($urandom);
      num_vec     = (c == 0) ? nv : 7'($urandom);
      l0_ready    = lr_tr[c];
      array_ready = ar_tr[c];
      l0_full     = full_tr[c];
      reset       = !(reset_at >= 0 && c == reset_at);
      @(negedge clk);
      chk($sformatf("cen@%0d", c),  sram_cen,  exp_cen[c]);
      chk($sformatf("addr@%0d", c), sram_addr, exp_addr[c]);
      chk($sformatf("wr@%0d", c),   l0_wr,     exp_wr[c]);
      chk($sformatf("rd@%0d", c),   l0_rd,     exp_rd[c]);
      chk($sformatf("busy@%0d", c), busy,      exp_busy[c]);
      chk($sformatf("done@%0d", c), done,      exp_done[c]);
      chk($sformatf("err@%0d", c),  err,       exp_err[c]);
      if (done === 1'b1) obs_done = c;
      if (l0_wr === 1'b1) n_wr++;
      if (l0_rd === 1'b1) n_rd++;
      if (sram_cen === 1'b0) n_cen++;
    end
    start     = 1'b0;
    prev_addr = exp_addr[last];
    prev_err  = exp_err[last];
  endtask

  initial begin
    int          od;
    int          nw;
    int          nr;
    int          nc;
    logic [6:0]  rnv;
    int          rn;

    reset       = 1'b0;
    start       = 1'b0;
    base_addr   = 11'd0;
    num_vec     = 7'd0;
    array_ready = 1'b1;
    l0_full     = 1'b0;
    l0_ready    = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cen",  sram_cen,  1'b1);
    chk("rst_addr", sram_addr, 11'd0);
    chk("rst_wr",   l0_wr,     1'b0);
    chk("rst_rd",   l0_rd,     1'b0);
    chk("rst_busy", busy,      1'b0);
    chk("rst_done", done,      1'b0);
    chk("rst_err",  err,       1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    // Nominal block.
    set_traces(1'b0);
    run_op(11'h010, 7'd4, 1'b0, -1, od, nw, nr, nc);
    chk("nominal_done_cycle", od, 18);
    chk("nominal_writes", nw, 4);
    chk("nominal_reads", nr, 4);
    chk("nominal_issues", nc, 4);

    // Zero length.
    set_traces(1'b0);
    run_op(11'h055, 7'd0, 1'b0, -1, od, nw, nr, nc);
    chk("zero_done_cycle", od, 1);
    chk("zero_writes", nw, 0);
    chk("zero_reads", nr, 0);
    chk("zero_issues", nc, 0);

    // L0 backpressure in cycles 3-4.
    set_traces(1'b0);
    lr_tr[3] = 1'b0;
    lr_tr[4] = 1'b0;
    run_op(11'h100, 7'd6, 1'b0, -1, od, nw, nr, nc);
    chk("l0_bp_done_cycle", od, 24);
    chk("l0_bp_writes", nw, 6);

    // Array backpressure for three drain cycles.
    set_traces(1'b0);
    ar_tr[8]  = 1'b0;
    ar_tr[9]  = 1'b0;
    ar_tr[10] = 1'b0;
    run_op(11'h200, 7'd6, 1'b0, -1, od, nw, nr, nc);
    chk("arr_bp_done_cycle", od, 25);
    chk("arr_bp_reads", nr, 6);

    // Address wrap.
    set_traces(1'b0);
    run_op(11'h7FE, 7'd4, 1'b0, -1, od, nw, nr, nc);
    chk("wrap_done_cycle", od, 18);

    // Clamp of an oversized request.
    set_traces(1'b0);
    run_op(11'h020, 7'd100, 1'b0, -1, od, nw, nr, nc);
    chk("clamp_writes", nw, 64);
    chk("clamp_reads", nr, 64);
    chk("clamp_done_cycle", od, 138);

    // Overflow during a write, with ignored starts mid-drain and at done.
    set_traces(1'b0);
    full_tr[3] = 1'b1;
    run_op(11'h300, 7'd4, 1'b1, -1, od, nw, nr, nc);
    chk("ovf_done_cycle", od, 18);
    chk("ovf_err_held", err, 1'b1);

    // Next accepted start clears err.
    set_traces(1'b0);
    run_op(11'h040, 7'd2, 1'b0, -1, od, nw, nr, nc);
    chk("clear_err", err, 1'b0);

    // Reset in the third drain cycle, then a fresh start.
    set_traces(1'b0);
    run_op(11'h0A0, 7'd6, 1'b0, 10, od, nw, nr, nc);
    chk("rst_mid_no_done", od, -1);
    set_traces(1'b0);
    run_op(11'h0B0, 7'd3, 1'b0, -1, od, nw, nr, nc);
    chk("after_rst_done_cycle", od, 16);

    // Randomized operations.
    for (int k = 0; k < 10; k++) begin
      set_traces(1'b1);
      rnv = 7'($urandom_range(0, 100));
      rn  = (rnv > 7'd64) ? 64 : int'(rnv);
      run_op(11'($urandom), rnv, 1'($urandom_range(0, 1)), -1, od, nw, nr, nc);
      chk($sformatf("rand%0d_writes", k), nw, rn);
      chk($sformatf("rand%0d_reads", k), nr, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
